// File: rtl/cpu_defs.sv
`default_nettype none
// =============================================================================
// Package  : cpu_defs
// Purpose  : Shared definitions for the load/store path: memory operation
//            encoding, exception codes, FSM state type and small decode
//            helpers used by the memory access unit and its bench.
// Revision : 1.0 - initial release
// =============================================================================
package cpu_defs;

    typedef enum logic [3:0] {
        LB  = 4'd0,
        LBU = 4'd1,
        LH  = 4'd2,
        LHU = 4'd3,
        LW  = 4'd4,
        LWU = 4'd5,
        LD  = 4'd6,
        SB  = 4'd7,
        SH  = 4'd8,
        SW  = 4'd9,
        SD  = 4'd10
    } mem_op_t;

    typedef logic [4:0] exc_code_t;

    localparam exc_code_t EX_ADEL = 5'd4;
    localparam exc_code_t EX_ADES = 5'd5;
    localparam exc_code_t EX_RI   = 5'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } mau_state_t;

    // Access size in bytes; 0 marks an encoding that is not a memory op.
    function automatic logic [3:0] op_size(input mem_op_t op);
        case (op)
            LB, LBU, SB:  return 4'd1;
            LH, LHU, SH:  return 4'd2;
            LW, LWU, SW:  return 4'd4;
            LD, SD:       return 4'd8;
            default:      return 4'd0;
        endcase
    endfunction

    function automatic logic op_is_store(input mem_op_t op);
        return (op == SB) || (op == SH) || (op == SW) || (op == SD);
    endfunction

    function automatic logic op_is_signed(input mem_op_t op);
        return (op == LB) || (op == LH) || (op == LW) || (op == LD);
    endfunction

    // Doubleword ops and LWU only exist on the 64-bit build.
    function automatic logic op_is_legal(input mem_op_t op, input int data_width);
        if (op_size(op) == 4'd0) begin
            return 1'b0;
        end
        if ((data_width == 32) && ((op == LD) || (op == SD) || (op == LWU))) begin
            return 1'b0;
        end
        return 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// =============================================================================
// Interface : mem_access_unit_if
// Purpose   : Data-bus (dbus) connection between the memory access unit
//             (master) and the memory system (slave). Valid/ready request
//             channel plus a single-beat response strobe.
// Signals   : req_valid/req_ready handshake, req_write, req_addr (bus-word
//             aligned), req_strobe (byte enables), req_data (lane-shifted),
//             resp_valid, resp_data (full bus word).
// Revision  : 1.0 - initial release
// =============================================================================
interface mem_access_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH/8-1:0] req_strobe;
    logic [DATA_WIDTH-1:0]   req_data;
    logic                    resp_valid;
    logic [DATA_WIDTH-1:0]   resp_data;

    modport master (
        output req_valid, req_write, req_addr, req_strobe, req_data,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_strobe, req_data,
        output req_ready, resp_valid, resp_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// =============================================================================
// Module   : mem_lane_align
// Purpose  : Combinational byte-lane steering for one access.
//            Store side: byte enables and store data shifted into the lanes
//            selected by the low address bits.
//            Load side: response word shifted down to bit 0 and sign/zero
//            extended from the access size.
// Ports    : size (bytes 1/2/4/8), is_signed, off (byte lane of access),
//            wdata -> strobe, sdata ; rdata -> ldata
// Revision : 1.0 - initial release
// =============================================================================
module mem_lane_align #(
    parameter  int DATA_WIDTH = 32,
    localparam int NB         = DATA_WIDTH / 8,
    localparam int OFFB       = $clog2(NB)
) (
    input  logic [3:0]            size,
    input  logic                  is_signed,
    input  logic [OFFB-1:0]       off,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [NB-1:0]         strobe,
    output logic [DATA_WIDTH-1:0] sdata,
    output logic [DATA_WIDTH-1:0] ldata
);

    logic [NB-1:0]         w_mask;
    logic [DATA_WIDTH-1:0] w_shr;
    logic                  w_msb;
    logic                  w_fill;

    // Contiguous run of 'size' enables starting at lane 0.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NB; i++) begin
            w_mask[i] = (i < int'(size));
        end
    end

    assign strobe = w_mask << off;
    assign sdata  = wdata << {off, 3'b000};
    assign w_shr  = rdata >> {off, 3'b000};

    always_comb begin
        case (size)
            4'd1:    w_msb = w_shr[7];
            4'd2:    w_msb = w_shr[15];
            4'd4:    w_msb = w_shr[31];
            default: w_msb = w_shr[DATA_WIDTH-1];
        endcase
        w_fill = w_msb & is_signed;
        ldata  = w_shr;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i >= 8 * int'(size)) begin
                ldata[i] = w_fill;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// =============================================================================
// Module   : mem_access_unit
// Purpose  : Multi-cycle load/store unit. Forms the effective address,
//            checks natural alignment, issues one dbus request, waits for the
//            response and returns extended load data or an exception.
// Ports    : clk, reset (async, active-high)
//            in_*   : op request (valid/ready) with op, base, offset, wdata
//            out_*  : result (valid/ready) with exc flag/code, badvaddr, rdata
//            dbus   : data-bus master port (mem_access_unit_if.master)
// Revision : 1.0 - initial release
// =============================================================================
module mem_access_unit
    import cpu_defs::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int OFFSET_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  mem_op_t                 in_op,
    input  logic [DATA_WIDTH-1:0]   in_base,
    input  logic [OFFSET_WIDTH-1:0] in_offset,
    input  logic [DATA_WIDTH-1:0]   in_wdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_exc,
    output exc_code_t               out_exc_code,
    output logic [ADDR_WIDTH-1:0]   out_badvaddr,
    output logic [DATA_WIDTH-1:0]   out_rdata,
    mem_access_unit_if.master       dbus
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFB = $clog2(NB);

    mau_state_t            r_state;
    mau_state_t            w_state_nxt;

    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [NB-1:0]         r_strobe;
    logic [DATA_WIDTH-1:0] r_data;
    logic [3:0]            r_size;
    logic                  r_signed;
    logic [OFFB-1:0]       r_off;
    logic                  r_exc;
    exc_code_t             r_exc_code;
    logic [ADDR_WIDTH-1:0] r_badvaddr;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [OFFB-1:0]       w_off;
    logic [3:0]            w_size;
    logic                  w_store;
    logic                  w_legal;
    logic                  w_misaligned;
    logic                  w_accept;
    logic [NB-1:0]         w_st_strobe;
    logic [DATA_WIDTH-1:0] w_st_data;
    logic [DATA_WIDTH-1:0] w_ld_data;
    logic [DATA_WIDTH-1:0] w_unused_st_ldata;
    logic [NB-1:0]         w_unused_ld_strobe;
    logic [DATA_WIDTH-1:0] w_unused_ld_sdata;

    // Effective address wraps modulo 2^ADDR_WIDTH; the signed cast
    // sign-extends the immediate.
    assign w_addr   = ADDR_WIDTH'(in_base) + ADDR_WIDTH'($signed(in_offset));
    assign w_off    = w_addr[OFFB-1:0];
    assign w_size   = op_size(in_op);
    assign w_store  = op_is_store(in_op);
    assign w_legal  = op_is_legal(in_op, DATA_WIDTH);
    assign w_accept = (r_state == S_IDLE) && in_valid;

    // Legal sizes never exceed the bus width, so only the lane bits matter.
    assign w_misaligned = |(w_off & OFFB'(w_size - 4'd1));

    mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_store_align (
        .size      (w_size),
        .is_signed (1'b0),
        .off       (w_off),
        .wdata     (in_wdata),
        .rdata     ('0),
        .strobe    (w_st_strobe),
        .sdata     (w_st_data),
        .ldata     (w_unused_st_ldata)
    );

    mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
        .size      (r_size),
        .is_signed (r_signed),
        .off       (r_off),
        .wdata     ('0),
        .rdata     (dbus.resp_data),
        .strobe    (w_unused_ld_strobe),
        .sdata     (w_unused_ld_sdata),
        .ldata     (w_ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        dbus.req_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = (!w_legal || w_misaligned) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                dbus.req_valid = 1'b1;
                if (dbus.req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dbus.resp_valid) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_strobe   <= '0;
            r_data     <= '0;
            r_size     <= '0;
            r_signed   <= 1'b0;
            r_off      <= '0;
            r_exc      <= 1'b0;
            r_exc_code <= '0;
            r_badvaddr <= '0;
            r_rdata    <= '0;
        end else if (w_accept) begin
            r_write    <= w_store;
            r_size     <= w_size;
            r_signed   <= op_is_signed(in_op);
            r_off      <= w_off;
            r_rdata    <= '0;
            r_addr     <= '0;
            r_strobe   <= '0;
            r_data     <= '0;
            r_badvaddr <= '0;
            if (!w_legal) begin
                r_exc      <= 1'b1;
                r_exc_code <= EX_RI;
            end else if (w_misaligned) begin
                r_exc      <= 1'b1;
                r_exc_code <= w_store ? EX_ADES : EX_ADEL;
                r_badvaddr <= w_addr;
            end else begin
                r_exc      <= 1'b0;
                r_exc_code <= '0;
                r_addr     <= {w_addr[ADDR_WIDTH-1:OFFB], {OFFB{1'b0}}};
                r_strobe   <= w_st_strobe;
                r_data     <= w_st_data;
            end
        end else if ((r_state == S_WAIT) && dbus.resp_valid) begin
            r_rdata <= r_write ? '0 : w_ld_data;
        end
    end

    assign dbus.req_write  = r_write;
    assign dbus.req_addr   = r_addr;
    assign dbus.req_strobe = r_strobe;
    assign dbus.req_data   = r_data;

    assign out_exc      = r_exc;
    assign out_exc_code = r_exc_code;
    assign out_badvaddr = r_badvaddr;
    assign out_rdata    = r_rdata;

endmodule
`default_nettype wire
